// File: rtl/chip8_memory.sv
// -----------------------------------------------------------------------------
// chip8_memory
//
// Responder end of the CPU memory interface. It holds a 2**ADDR_W byte,
// single-port RAM. After reset an internal sequencer copies the 80-byte hex
// font into RAM at FONT_BASE, one byte per cycle. Once the copy is done, the
// RAM serves three requesters. Only one access is allowed per cycle, with
// priority: CPU write > loader > CPU read.
//
// Ports
//   clk, rst_n      : clock and asynchronous active-low reset
//   mem_read        : CPU read request, re-asserted by the CPU until acked
//   mem_read_addr   : CPU read address
//   mem_read_data   : read data, valid while mem_read_ack is high
//   mem_read_ack    : one-cycle pulse, one cycle after a serviced read
//   mem_write       : CPU write strobe, one byte per cycle, never blocked
//   mem_write_addr  : CPU write address
//   mem_write_data  : CPU write data
//   load_valid      : loader byte offered
//   load_addr       : loader target address
//   load_data       : loader byte
//   load_ready      : loader byte taken this cycle when load_valid is high
//   init_done       : high once the font copy has completed
// -----------------------------------------------------------------------------
module chip8_memory #(
    parameter int                ADDR_W     = 12,
    parameter logic [ADDR_W-1:0] FONT_BASE  = '0,
    parameter int                FONT_BYTES = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] mem_read_addr,
    output logic [7:0]        mem_read_data,
    output logic              mem_read_ack,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_write_addr,
    input  logic [7:0]        mem_write_data,
    input  logic              load_valid,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              init_done
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [6:0] FONT_END = 7'(FONT_BYTES - 1);

    // Standard CHIP-8 glyphs 0..F, five rows each.
    localparam logic [7:0] FONT_ROM [0:79] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
        8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
        8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
        8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
        8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
        8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
        8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
        8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
    };

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic [7:0]        ram_q [DEPTH];

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              rd_fire;

    // The loader is refused only by INIT or a competing CPU write.
    assign load_ready = (state_q == ST_RUN) & ~mem_write;
    assign init_done  = (state_q == ST_RUN);

    // Port arbitration and sequencing. A CPU read wins the port only when
    // nothing else wants it; a losing read is simply dropped and the CPU
    // repeats it.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we        = 1'b0;
        waddr     = mem_write_addr;
        wdata     = mem_write_data;
        rd_fire   = 1'b0;
        case (state_q)
            ST_INIT: begin
                we    = 1'b1;
                waddr = FONT_BASE + ADDR_W'(cnt_q);
                wdata = FONT_ROM[cnt_q];
                if (cnt_q == FONT_END) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_RUN: begin
                if (mem_write) begin
                    we = 1'b1;
                end else if (load_valid) begin
                    we    = 1'b1;
                    waddr = load_addr;
                    wdata = load_data;
                end else if (mem_read) begin
                    rd_fire = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
        ack_d     = rd_fire;
        rd_data_d = rd_fire ? ram_q[mem_read_addr] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RAM contents survive reset, so the array has no reset branch.
    always_ff @(posedge clk) begin
        if (we) begin
            ram_q[waddr] <= wdata;
        end
    end

    assign mem_read_ack  = ack_q;
    assign mem_read_data = rd_data_q;

endmodule

// File: tb/tb_chip8_memory.sv
module tb_chip8_memory;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic [11:0] mem_read_addr;
    logic [7:0]  mem_read_data;
    logic        mem_read_ack;
    logic        mem_write;
    logic [11:0] mem_write_addr;
    logic [7:0]  mem_write_data;
    logic        load_valid;
    logic [11:0] load_addr;
    logic [7:0]  load_data;
    logic        load_ready;
    logic        init_done;

    chip8_memory #(.ADDR_W(12), .FONT_BASE(12'h000), .FONT_BYTES(80)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_read_addr  (mem_read_addr),
        .mem_read_data  (mem_read_data),
        .mem_read_ack   (mem_read_ack),
        .mem_write      (mem_write),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .load_valid     (load_valid),
        .load_addr      (load_addr),
        .load_data      (load_data),
        .load_ready     (load_ready),
        .init_done      (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        bit          known;
        int unsigned tag;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: byte array plus "known" flags, and a countdown of
    // font-copy cycles still to go after reset release.
    logic [7:0] m_mem   [4096];
    bit         m_known [4096];
    int         init_left;
    logic [39:0] glyph [16];
    logic [7:0]  font_m [80];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ack must match the oldest outstanding serviced read.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_ack actual=ack required=no_ack (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.tag + 1 != cyc) begin
                        errors++;
                        $display("FAIL ack_latency actual=%0d required=%0d", cyc - e.tag, 1);
                    end else if (e.known && mem_read_data !== e.data) begin
                        errors++;
                        $display("FAIL read_data actual=%0h required=%0h (cycle %0d)",
                                 mem_read_data, e.data, cyc);
                    end
                end
            end
            if (exp_q.size() > 1) begin
                checks++;
                errors++;
                $display("FAIL missing_ack actual=no_ack required=ack (cycle %0d)", cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic release_reset();
        rst_n = 1'b1;
        init_left = 80;
        for (int k = 0; k < 80; k++) begin
            m_mem[k]   = font_m[k];
            m_known[k] = 1'b1;
        end
    endtask

    // One clock cycle of stimulus, starting 1 time unit after a rising edge.
    task automatic step(input bit rd, input logic [11:0] ra,
                        input bit wr, input logic [11:0] wa, input logic [7:0] wd,
                        input bit lv, input logic [11:0] la, input logic [7:0] ld);
        bit run;
        mem_read = rd; mem_read_addr = ra;
        mem_write = wr; mem_write_addr = wa; mem_write_data = wd;
        load_valid = lv; load_addr = la; load_data = ld;
        #1;
        run = (init_left == 0);
        chk("init_done", {7'd0, init_done}, {7'd0, run});
        chk("load_ready", {7'd0, load_ready}, {7'd0, run && !wr});
        if (run) begin
            if (wr) begin
                m_mem[wa] = wd; m_known[wa] = 1'b1;
            end else if (lv) begin
                m_mem[la] = ld; m_known[la] = 1'b1;
            end else if (rd) begin
                exp_q.push_back('{data: m_mem[ra], known: m_known[ra], tag: cyc});
            end
        end
        @(posedge clk);
        if (init_left > 0) init_left--;
        #1;
    endtask

    task automatic idle();
        step(0, 12'h0, 0, 12'h0, 8'h0, 0, 12'h0, 8'h0);
    endtask

    task automatic rd(input logic [11:0] a);
        step(1, a, 0, 12'h0, 8'h0, 0, 12'h0, 8'h0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [7:0] d);
        step(0, 12'h0, 1, a, d, 0, 12'h0, 8'h0);
    endtask

    task automatic ld(input logic [11:0] a, input logic [7:0] d);
        step(0, 12'h0, 0, 12'h0, 8'h0, 1, a, d);
    endtask

    initial begin
        glyph = '{40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
                  40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
                  40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
                  40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080};
        for (int k = 0; k < 80; k++) begin
            logic [39:0] g;
            g = glyph[k / 5];
            font_m[k] = g[39 - 8 * (k % 5) -: 8];
        end
        for (int a = 0; a < 4096; a++) begin
            m_mem[a] = 8'h00; m_known[a] = 1'b0;
        end
        init_left = 80;

        rst_n = 1'b0;
        mem_read = 0; mem_read_addr = '0; mem_write = 0; mem_write_addr = '0;
        mem_write_data = '0; load_valid = 1'b1; load_addr = '0; load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {7'd0, mem_read_ack}, 8'd0);
        chk("rst_data", mem_read_data, 8'd0);
        chk("rst_ready", {7'd0, load_ready}, 8'd0);
        chk("rst_init_done", {7'd0, init_done}, 8'd0);
        release_reset();

        // Reads held from release: no ack during INIT, then font bytes.
        repeat (81) rd(12'h000);
        rd(12'h005);
        rd(12'h04F);
        idle();

        // Loader stream, then back-to-back reads.
        ld(12'h200, 8'h12);
        ld(12'h201, 8'h34);
        rd(12'h200);
        rd(12'h201);
        idle();

        // Write beats loader and read; read next cycle sees the new byte.
        step(1, 12'h300, 1, 12'h300, 8'hAB, 1, 12'h210, 8'h77);
        rd(12'h300);
        ld(12'h210, 8'h77);
        rd(12'h210);

        // Loader beats read; repeated read gets the ack.
        step(1, 12'h201, 0, 12'h0, 8'h0, 1, 12'h211, 8'h5A);
        rd(12'h201);
        rd(12'h211);
        idle();

        // Randomized traffic over a prefilled window plus the font region.
        for (int i = 0; i < 64; i++) ld(12'h600 + 12'(i), 8'($urandom));
        for (int i = 0; i < 600; i++) begin
            logic [11:0] ra;
            ra = ($urandom % 4 == 0) ? 12'($urandom % 80) : 12'h600 + 12'($urandom % 64);
            step($urandom % 2 == 0, ra,
                 $urandom % 4 == 0, 12'h600 + 12'($urandom % 64), 8'($urandom),
                 $urandom % 3 == 0, 12'h600 + 12'($urandom % 64), 8'($urandom));
        end
        idle();

        // Mid-run reset while an ack is showing.
        wr(12'h400, 8'h55);
        rd(12'h400);
        chk("pre_reset_ack", {7'd0, mem_read_ack}, 8'd1);
        exp_q.delete();
        mem_read = 0; mem_write = 0; load_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_ack", {7'd0, mem_read_ack}, 8'd0);
        chk("async_ready", {7'd0, load_ready}, 8'd0);
        chk("async_init_done", {7'd0, init_done}, 8'd0);
        @(posedge clk); @(posedge clk); #1;
        release_reset();
        // CPU write during INIT must be dropped.
        wr(12'h400, 8'h99);
        repeat (80) rd(12'h400);
        rd(12'h400);
        for (int i = 0; i < 16; i++) rd(12'($urandom % 80));
        idle();

        // Loader overwrites the font, reset restores it.
        ld(12'h000, 8'h00);
        rd(12'h000);
        idle();
        rst_n = 1'b0;
        @(posedge clk); #1;
        release_reset();
        repeat (80) idle();
        rd(12'h000);
        rd(12'h04B);
        rd(12'h400);
        repeat (3) idle();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_acks actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
